// File: rtl/phase_timer_pkg.sv
// Shared types and default parameters for the phase_timer block.
package phase_timer_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } ch_state_e;

    localparam int DEF_PRESCALE = 50;
    localparam int DEF_CNT_W    = 28;
    localparam int DEF_N_CH     = 4;
    localparam int DEF_DUR_W    = 8;

endpackage

// File: rtl/phase_timer_tick_prescaler.sv
// Base tick generator: counts clk cycles while enabled and emits a one-cycle
// registered tick every PRESCALE cycles; holds its phase while disabled.
module tick_prescaler #(
    parameter int PRESCALE = phase_timer_pkg::DEF_PRESCALE,
    parameter int CNT_W    = phase_timer_pkg::DEF_CNT_W
) (
    input  logic clk,
    input  logic reset,
    input  logic en_i,
    output logic tick_o
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(PRESCALE - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick_q, tick_d;

    always_comb begin
        cnt_d  = cnt_q;
        tick_d = 1'b0;
        if (en_i) begin
            if (cnt_q == LAST) begin
                cnt_d  = '0;
                tick_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    // Gate with en so a pending tick never leaks out while the timer is paused.
    assign tick_o = tick_q & en_i;

endmodule

// File: rtl/phase_timer.sv
// Multi-channel tick-based countdown timer sharing one prescaler.
// Optional auto-reload on expiry is compiled in with PHASE_TIMER_RELOAD_EN.
module phase_timer
    import phase_timer_pkg::*;
#(
    parameter int PRESCALE = DEF_PRESCALE,
    parameter int CNT_W    = DEF_CNT_W,
    parameter int N_CH     = DEF_N_CH,
    parameter int DUR_W    = DEF_DUR_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic [N_CH-1:0]       start,
    input  logic [N_CH*DUR_W-1:0] dur,
    input  logic [N_CH-1:0]       abort,
`ifdef PHASE_TIMER_RELOAD_EN
    input  logic [N_CH-1:0]       reload,
`endif
    output logic                  tick,
    output logic [N_CH-1:0]       busy,
    output logic [N_CH-1:0]       done,
    output logic [N_CH*DUR_W-1:0] remaining
);

    logic tick_w;

    tick_prescaler #(
        .PRESCALE (PRESCALE),
        .CNT_W    (CNT_W)
    ) u_prescaler (
        .clk    (clk),
        .reset  (reset),
        .en_i   (en),
        .tick_o (tick_w)
    );

    assign tick = tick_w;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        ch_state_e        st_q, st_d;
        logic [DUR_W-1:0] rem_q, rem_d;
        logic [DUR_W-1:0] lat_q, lat_d;
        logic             done_q, done_d;
        logic [DUR_W-1:0] dur_w;
        logic             rld;

        assign dur_w = dur[i*DUR_W +: DUR_W];
`ifdef PHASE_TIMER_RELOAD_EN
        assign rld = reload[i];
`else
        assign rld = 1'b0;
`endif

        always_comb begin
            st_d   = st_q;
            rem_d  = rem_q;
            lat_d  = lat_q;
            done_d = 1'b0;
            if (abort[i]) begin
                st_d  = IDLE;
                rem_d = '0;
            end else begin
                case (st_q)
                    IDLE: begin
                        if (start[i]) begin
                            if (dur_w != '0) begin
                                st_d  = RUN;
                                rem_d = dur_w;
                                lat_d = dur_w;
                            end else begin
                                done_d = 1'b1;
                            end
                        end
                    end
                    RUN: begin
                        if (tick_w) begin
                            if (rem_q <= DUR_W'(1)) begin
                                done_d = 1'b1;
                                if (rld) begin
                                    rem_d = lat_q;
                                end else begin
                                    st_d  = IDLE;
                                    rem_d = '0;
                                end
                            end else if (rem_q > lat_q) begin
                                // Never let remaining exceed the latched duration.
                                rem_d = lat_q;
                            end else begin
                                rem_d = rem_q - DUR_W'(1);
                            end
                        end
                    end
                    default: begin
                        st_d  = IDLE;
                        rem_d = '0;
                    end
                endcase
            end
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                st_q   <= IDLE;
                rem_q  <= '0;
                lat_q  <= '0;
                done_q <= 1'b0;
            end else begin
                st_q   <= st_d;
                rem_q  <= rem_d;
                lat_q  <= lat_d;
                done_q <= done_d;
            end
        end

        assign busy[i]                   = (st_q == RUN);
        assign done[i]                   = done_q;
        assign remaining[i*DUR_W +: DUR_W] = rem_q;
    end

endmodule

// File: tb/tb_phase_timer.sv
// Directed bench for phase_timer with PRESCALE=4; cycle k counts rising edges
// since reset release, outputs sampled on the following falling edge.
module tb_phase_timer;

    localparam int PRESCALE = 4;
    localparam int CNT_W    = 8;
    localparam int N_CH     = 4;
    localparam int DUR_W    = 8;

    logic                  clk = 1'b0;
    logic                  reset = 1'b1;
    logic                  en = 1'b0;
    logic [N_CH-1:0]       start = '0;
    logic [N_CH*DUR_W-1:0] dur = '0;
    logic [N_CH-1:0]       abort = '0;
`ifdef PHASE_TIMER_RELOAD_EN
    logic [N_CH-1:0]       reload = '0;
`endif
    logic                  tick;
    logic [N_CH-1:0]       busy;
    logic [N_CH-1:0]       done;
    logic [N_CH*DUR_W-1:0] remaining;

    int n_vec = 0;
    int n_err = 0;

    phase_timer #(
        .PRESCALE (PRESCALE),
        .CNT_W    (CNT_W),
        .N_CH     (N_CH),
        .DUR_W    (DUR_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .start     (start),
        .dur       (dur),
        .abort     (abort),
`ifdef PHASE_TIMER_RELOAD_EN
        .reload    (reload),
`endif
        .tick      (tick),
        .busy      (busy),
        .done      (done),
        .remaining (remaining)
    );

    always #5 clk = ~clk;

    function automatic logic [DUR_W-1:0] rem(input int i);
        return remaining[i*DUR_W +: DUR_W];
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1; en = 1'b0; start = '0; abort = '0; dur = '0;
`ifdef PHASE_TIMER_RELOAD_EN
        reload = '0;
`endif
        repeat (2) @(negedge clk);
        reset = 1'b0;
        en    = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1; en = 1'b1;
        repeat (3) @(negedge clk);
        n_vec++;
        if ({tick, busy, done, remaining} !== '0) begin
            n_err++;
            $display("FAIL reset_state got tick=%b busy=%b done=%b rem=%h exp all zero",
                     tick, busy, done, remaining);
        end
    endtask

    task automatic test_tick_period();
        logic exp;
        do_reset();
        for (int k = 1; k <= 13; k++) begin
            step();
            exp = (k % 4 == 0);
            n_vec++;
            if (tick !== exp) begin
                n_err++;
                $display("FAIL tick_period k=%0d got %b exp %b", k, tick, exp);
            end
        end
    endtask

    task automatic test_en_gap();
        logic exp;
        do_reset();
        for (int k = 1; k <= 15; k++) begin
            en = !(k >= 3 && k <= 5);
            step();
            exp = (k == 7 || k == 11 || k == 15);
            n_vec++;
            if (tick !== exp) begin
                n_err++;
                $display("FAIL en_gap k=%0d got %b exp %b", k, tick, exp);
            end
        end
    endtask

    task automatic test_oneshot();
        logic [DUR_W-1:0] erem;
        logic             ebusy, edone;
        do_reset();
        dur[0 +: DUR_W] = 8'd3;
        start[0] = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            step();
            start = '0;
            ebusy = (k <= 12);
            edone = (k == 13);
            erem  = (k <= 4) ? 8'd3 : (k <= 8) ? 8'd2 : (k <= 12) ? 8'd1 : 8'd0;
            n_vec++;
            if ({busy[0], done[0], rem(0)} !== {ebusy, edone, erem}) begin
                n_err++;
                $display("FAIL oneshot k=%0d got busy=%b done=%b rem=%0d exp busy=%b done=%b rem=%0d",
                         k, busy[0], done[0], rem(0), ebusy, edone, erem);
            end
        end
    endtask

    task automatic test_zero_and_tick_start();
        logic [DUR_W-1:0] erem;
        do_reset();
        dur[1*DUR_W +: DUR_W] = 8'd0;
        start[1] = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            step();
            start = '0;
            if (k == 1) begin
                n_vec++;
                if ({busy[1], done[1]} !== 2'b01) begin
                    n_err++;
                    $display("FAIL zero_dur k=1 got busy=%b done=%b exp busy=0 done=1", busy[1], done[1]);
                end
            end else begin
                n_vec++;
                if ({busy[1], done[1]} !== 2'b00) begin
                    n_err++;
                    $display("FAIL zero_dur k=%0d got busy=%b done=%b exp 0 0", k, busy[1], done[1]);
                end
            end
            if (k == 4) begin
                // tick is high in this cycle; start lands on it
                dur[2*DUR_W +: DUR_W] = 8'd2;
                start[2] = 1'b1;
            end
            if (k >= 5) begin
                erem = (k <= 8) ? 8'd2 : (k <= 12) ? 8'd1 : 8'd0;
                n_vec++;
                if ({busy[2], done[2], rem(2)} !== {(k <= 12), (k == 13), erem}) begin
                    n_err++;
                    $display("FAIL tick_start k=%0d got busy=%b done=%b rem=%0d exp busy=%b done=%b rem=%0d",
                             k, busy[2], done[2], rem(2), (k <= 12), (k == 13), erem);
                end
            end
        end
    endtask

    task automatic test_abort_and_restart();
        do_reset();
        dur[0 +: DUR_W]        = 8'd1;
        dur[3*DUR_W +: DUR_W]  = 8'd5;
        start = 4'b1001;
        step();
        start = '0;
        dur[3*DUR_W +: DUR_W] = 8'd9;
        start[3] = 1'b1;
        step();
        start = '0;
        n_vec++;
        if ({busy[3], rem(3)} !== {1'b1, 8'd5}) begin
            n_err++;
            $display("FAIL start_in_run got busy=%b rem=%0d exp busy=1 rem=5", busy[3], rem(3));
        end
        step(); step();
        abort[0] = 1'b1;
        step();
        abort = '0;
        n_vec++;
        if ({busy[0], done[0], rem(0)} !== {1'b0, 1'b0, 8'd0}) begin
            n_err++;
            $display("FAIL abort_vs_expiry got busy=%b done=%b rem=%0d exp 0 0 0", busy[0], done[0], rem(0));
        end
        n_vec++;
        if (rem(3) !== 8'd4) begin
            n_err++;
            $display("FAIL abort_isolation got rem3=%0d exp 4", rem(3));
        end
        step();
        n_vec++;
        if (done[0] !== 1'b0) begin
            n_err++;
            $display("FAIL abort_no_done got done0=%b exp 0", done[0]);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        dur = {8'd0, 8'd0, 8'd1, 8'd1};
        start = 4'b0011;
        step();
        start = '0;
        repeat (3) step();
        n_vec++;
        if ({busy, done} !== {4'b0011, 4'b0000}) begin
            n_err++;
            $display("FAIL simul_pre got busy=%b done=%b exp 0011 0000", busy, done);
        end
        step();
        n_vec++;
        if ({busy, done} !== {4'b0000, 4'b0011}) begin
            n_err++;
            $display("FAIL simul_expiry got busy=%b done=%b exp 0000 0011", busy, done);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        dur[0 +: DUR_W] = 8'd3;
        start[0] = 1'b1;
        step();
        start = '0;
        repeat (5) step();
        n_vec++;
        if (rem(0) !== 8'd2) begin
            n_err++;
            $display("FAIL reset_mid_pre got rem0=%0d exp 2", rem(0));
        end
        reset = 1'b1;
        #1;
        n_vec++;
        if ({tick, busy, done, remaining} !== '0) begin
            n_err++;
            $display("FAIL reset_async got busy=%b rem=%h exp 0", busy, remaining);
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            step();
            n_vec++;
            if ({tick, busy[0], done[0]} !== {(k == 4), 1'b0, 1'b0}) begin
                n_err++;
                $display("FAIL reset_mid_after k=%0d got tick=%b busy=%b done=%b exp tick=%b 0 0",
                         k, tick, busy[0], done[0], (k == 4));
            end
        end
    endtask

`ifdef PHASE_TIMER_RELOAD_EN
    task automatic test_reload();
        logic [DUR_W-1:0] erem;
        logic             edone;
        do_reset();
        reload[0] = 1'b1;
        dur[0 +: DUR_W] = 8'd2;
        start[0] = 1'b1;
        for (int k = 1; k <= 18; k++) begin
            step();
            start = '0;
            edone = (k == 9 || k == 17);
            erem  = ((k - 1) % 8 < 4) ? 8'd2 : 8'd1;
            n_vec++;
            if ({busy[0], done[0], rem(0)} !== {1'b1, edone, erem}) begin
                n_err++;
                $display("FAIL reload k=%0d got busy=%b done=%b rem=%0d exp busy=1 done=%b rem=%0d",
                         k, busy[0], done[0], rem(0), edone, erem);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_tick_period();
        test_en_gap();
        test_oneshot();
        test_zero_and_tick_start();
        test_abort_and_restart();
        test_back_to_back();
        test_reset_mid();
`ifdef PHASE_TIMER_RELOAD_EN
        test_reload();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
